// File: rtl/sram_line_fill_ctrl.sv
// Line-fill controller for a narrow asynchronous SRAM: splits CPU words into SRAM beats,
// writes through on stores and refetches the full aligned cache line for the cache.
module sram_line_fill_ctrl #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned SRAM_W     = 16,
   parameter int unsigned ADDR_W     = 18,
   parameter int unsigned LINE_WORDS = 2,
   parameter int unsigned WAIT_CYC   = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         req_wr,
   input  logic                         req_rd,
   input  logic                         hit,
   input  logic [31:0]                  addr_in,
   input  logic [DATA_W-1:0]            wdata,
   inout  wire  [SRAM_W-1:0]            sram_dq,
   output logic [ADDR_W-1:0]            sram_addr,
   output logic                         sram_we_n,
   output logic [DATA_W-1:0]            rdata,
   output logic [LINE_WORDS*DATA_W-1:0] line_data,
   output logic                         line_we,
   output logic [ADDR_W-1:0]            line_base,
   output logic                         ready
);

   localparam int unsigned BEATS      = DATA_W / SRAM_W;
   localparam int unsigned LINE_BEATS = BEATS * LINE_WORDS;
   localparam int unsigned BEAT_LG    = $clog2(BEATS);
   localparam int unsigned LINE_LG    = $clog2(LINE_BEATS);
   localparam int unsigned WORD_LG    = $clog2(LINE_WORDS);
   localparam int unsigned IDX_W      = (LINE_LG > 0) ? LINE_LG : 1;
   localparam int unsigned CRIT_W     = (WORD_LG > 0) ? WORD_LG : 1;
   localparam int unsigned WAIT_W     = 4;

   localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(BEATS - 1);
   localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BEATS - 1);

   typedef enum logic [2:0] {
      IDLE,
      WR_BEAT,
      RD_BEAT,
      LINE_WR,
      DONE
   } state_t;

   state_t              state, state_n;
   logic [IDX_W-1:0]    idx, idx_n;
   logic [WAIT_W-1:0]   wcnt, wcnt_n;
   logic [ADDR_W-1:0]   a_q, a_n;
   logic [DATA_W-1:0]   wd_q, wd_n;
   logic [ADDR_W-1:0]   base_n;
   logic [ADDR_W-1:0]   addr_n;
   logic [CRIT_W-1:0]   crit;
   logic                miss;
   logic                beat_end;
   logic                dq_oe;
   logic [SRAM_W-1:0]   dq_out;

   assign miss     = req_rd & ~hit;
   assign beat_end = (wcnt == WAIT_W'(WAIT_CYC));
   assign sram_dq  = dq_oe ? dq_out : {SRAM_W{1'bz}};

   // Upper address bits beyond the SRAM range are intentionally ignored.
   if (ADDR_W < 32) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr_in[31:ADDR_W];
   end

   // Word offset of the critical word within the fetched line.
   assign crit = CRIT_W'((a_q - line_base) >> BEAT_LG);

   // Next-state, beat sequencing and combinational ready.
   always_comb begin
      state_n = state;
      idx_n   = idx;
      wcnt_n  = wcnt;
      a_n     = a_q;
      wd_n    = wd_q;
      ready   = 1'b0;
      case (state)
         IDLE: begin
            ready  = ~req_wr & ~miss;
            idx_n  = '0;
            wcnt_n = '0;
            if (req_wr) begin
               a_n     = addr_in[ADDR_W-1:0] & WORD_MASK;
               wd_n    = wdata;
               state_n = WR_BEAT;
            end else if (miss) begin
               a_n     = addr_in[ADDR_W-1:0] & WORD_MASK;
               state_n = RD_BEAT;
            end
         end
         WR_BEAT: begin
            if (beat_end) begin
               wcnt_n = '0;
               if (idx == IDX_W'(BEATS - 1)) begin
                  idx_n   = '0;
                  state_n = RD_BEAT;
               end else begin
                  idx_n = idx + IDX_W'(1);
               end
            end else begin
               wcnt_n = wcnt + WAIT_W'(1);
            end
         end
         RD_BEAT: begin
            if (beat_end) begin
               wcnt_n = '0;
               if (idx == IDX_W'(LINE_BEATS - 1)) begin
                  idx_n   = '0;
                  state_n = LINE_WR;
               end else begin
                  idx_n = idx + IDX_W'(1);
               end
            end else begin
               wcnt_n = wcnt + WAIT_W'(1);
            end
         end
         LINE_WR: state_n = DONE;
         DONE: begin
            ready   = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // SRAM address for the upcoming cycle, so the pins can be registered.
   always_comb begin
      base_n = a_n & LINE_MASK;
      addr_n = sram_addr;
      if (state_n == WR_BEAT) begin
         addr_n = a_n + ADDR_W'(idx_n);
      end else if (state_n == RD_BEAT) begin
         addr_n = base_n + ADDR_W'(idx_n);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
         wcnt  <= '0;
         a_q   <= '0;
         wd_q  <= '0;
      end else begin
         state <= state_n;
         idx   <= idx_n;
         wcnt  <= wcnt_n;
         a_q   <= a_n;
         wd_q  <= wd_n;
      end
   end

   // Registered SRAM pins and cache-side results; reset drops the bus at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sram_addr <= '0;
         sram_we_n <= 1'b1;
         dq_oe     <= 1'b0;
         dq_out    <= '0;
         line_we   <= 1'b0;
         line_base <= '0;
         line_data <= '0;
         rdata     <= '0;
      end else begin
         sram_addr <= addr_n;
         sram_we_n <= (state_n != WR_BEAT);
         dq_oe     <= (state_n == WR_BEAT);
         dq_out    <= SRAM_W'(wd_n >> (int'(idx_n) * SRAM_W));
         line_we   <= (state_n == LINE_WR);
         if (state == IDLE && state_n != IDLE) begin
            line_base <= base_n;
         end
         if (state == RD_BEAT && beat_end) begin
            line_data[int'(idx)*SRAM_W +: SRAM_W] <= sram_dq;
         end
         if (state == LINE_WR) begin
            rdata <= DATA_W'(line_data >> (int'(crit) * DATA_W));
         end
      end
   end

endmodule
